ram_arbiter: RTL

Parametrised N-client arbiter in front of a single-port RAM, the next generation of the two-client priority encoders that share the image and histogram RAMs between decoder and filter. It accepts per-client read/write requests and issues at most one access per cycle through registered RAM control. It supports fixed-priority and round-robin modes and returns read data with a per-client valid strobe. An optional lock feature lets one client own the RAM for bursts.

---
 rtl/ram_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// N-client arbiter for one single-port RAM: fixed-priority or round-robin, optional burst lock (RAM_ARBITER_LOCK_EN).
// Latency: request seen at edge e -> gnt/RAM controls registered after e; rdata_valid READ_LATENCY cycles after gnt.
// Backpressure: clients hold req until gnt; a just-granted client is masked for one edge (except a lock owner).
module ram_arbiter #(
    parameter int NUM_CLIENTS   = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 17,
    parameter int READ_LATENCY  = 1,
    parameter int MODE          = 0
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NUM_CLIENTS-1:0]               req_i,
    input  logic [NUM_CLIENTS-1:0]               we_i,
    input  logic [NUM_CLIENTS*ADDRESS_WIDTH-1:0] address_i,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0]    wdata_i,
`ifdef RAM_ARBITER_LOCK_EN
    input  logic [NUM_CLIENTS-1:0]               lock_i,
`endif
    output logic [NUM_CLIENTS-1:0]               gnt_o,
    output logic [DATA_WIDTH-1:0]                rdata_o,
    output logic [NUM_CLIENTS-1:0]               rdata_valid_o,
    output logic                                 ram_CE_o,
    output logic                                 ram_WE_o,
    output logic [ADDRESS_WIDTH-1:0]             ram_address_o,
    output logic [DATA_WIDTH-1:0]                ram_data_output_o,
    input  logic [DATA_WIDTH-1:0]                ram_data_input_i
);

    localparam int IDXW = $clog2(NUM_CLIENTS);

    // Registered issue state
    logic [NUM_CLIENTS-1:0]   gnt_q, gnt_d;
    logic                     ce_q, ce_d;
    logic                     we_q, we_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdat_q, wdat_d;
    logic [IDXW-1:0]          idx_q, idx_d;
    logic [IDXW-1:0]          ptr_q, ptr_d;

    // Read tag pipeline: stage 0 holds the access issued in the previous cycle
    logic [READ_LATENCY-1:0]  tag_vld_q;
    logic [IDXW-1:0]          tag_idx_q [READ_LATENCY];

    logic [NUM_CLIENTS-1:0]   elig;
    logic                     win_vld;
    logic [IDXW-1:0]          win_idx;
    logic                     own_act;

`ifdef RAM_ARBITER_LOCK_EN
    logic                     own_vld_q;
    logic [IDXW-1:0]          own_idx_q;

    // An owner whose lock is still high is the only eligible client and skips the re-grant mask
    always_comb begin
        own_act = own_vld_q & lock_i[own_idx_q];
        elig    = req_i & ~gnt_q;
        if (own_act) begin
            elig          = '0;
            elig[own_idx_q] = req_i[own_idx_q];
        end
    end

    // Ownership starts on a locked grant and ends at the first edge the owner's lock is low
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            own_vld_q <= 1'b0;
            own_idx_q <= '0;
        end else if (!own_act) begin
            if (win_vld && lock_i[win_idx]) begin
                own_vld_q <= 1'b1;
                own_idx_q <= win_idx;
            end else begin
                own_vld_q <= 1'b0;
            end
        end
    end
`else
    // Without lock support every client is masked for one edge after its grant
    always_comb begin
        own_act = 1'b0;
        elig    = req_i & ~gnt_q;
    end
`endif

    // Winner selection: lowest index, or first index at/after the round-robin pointer
    always_comb begin
        int j;
        win_vld = 1'b0;
        win_idx = '0;
        j       = 0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            if (MODE == 0) begin
                j = k;
            end else begin
                j = int'(ptr_q) + k;
                if (j >= NUM_CLIENTS) j = j - NUM_CLIENTS;
            end
            if (!win_vld && elig[j]) begin
                win_vld = 1'b1;
                win_idx = IDXW'(j);
            end
        end
    end

    // Next issue state: payload of the winner, address/data hold when idle
    always_comb begin
        gnt_d  = '0;
        ce_d   = win_vld;
        we_d   = 1'b0;
        addr_d = addr_q;
        wdat_d = wdat_q;
        idx_d  = idx_q;
        ptr_d  = ptr_q;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (win_vld && win_idx == IDXW'(i)) begin
                gnt_d[i] = 1'b1;
                we_d     = we_i[i];
                addr_d   = address_i[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                wdat_d   = wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                idx_d    = win_idx;
            end
        end
        // Pointer frozen during ownership; the grant that created ownership already moved it past the owner
        if (win_vld && !own_act) begin
            ptr_d = (win_idx == IDXW'(NUM_CLIENTS-1)) ? '0 : win_idx + 1'b1;
        end
    end

    // Issue registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gnt_q  <= '0;
            ce_q   <= 1'b0;
            we_q   <= 1'b0;
            addr_q <= '0;
            wdat_q <= '0;
            idx_q  <= '0;
            ptr_q  <= '0;
        end else begin
            gnt_q  <= gnt_d;
            ce_q   <= ce_d;
            we_q   <= we_d;
            addr_q <= addr_d;
            wdat_q <= wdat_d;
            idx_q  <= idx_d;
            ptr_q  <= ptr_d;
        end
    end

    // Tag shift register: reads only, so writes never raise rdata_valid
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_vld_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) tag_idx_q[i] <= '0;
        end else begin
            tag_vld_q[0] <= ce_q & ~we_q;
            tag_idx_q[0] <= idx_q;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_idx_q[i] <= tag_idx_q[i-1];
            end
        end
    end

    // Decode the last tag stage into the per-client valid strobe
    always_comb begin
        rdata_valid_o = '0;
        if (tag_vld_q[READ_LATENCY-1]) rdata_valid_o[tag_idx_q[READ_LATENCY-1]] = 1'b1;
    end

    assign gnt_o             = gnt_q;
    assign ram_CE_o          = ce_q;
    assign ram_WE_o          = we_q;
    assign ram_address_o     = addr_q;
    assign ram_data_output_o = wdat_q;
    assign rdata_o           = ram_data_input_i;

endmodule
